message_field_store: RTL

Commits per-lane field replacements from the decode write-back stage into a per-message field buffer. Tracks which fields of the open message have arrived and hands a completed message downstream over a valid/ready interface. Double-buffered (fill bank + output bank), so one message can assemble while the previous one waits for the consumer. Sits directly after write-back, before order-book/strategy logic.

---
 rtl/fast_pkg.sv | 23 ++
 rtl/lane_merge.sv | 32 +++
 rtl/message_field_store.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fast_pkg.sv
// Shared definitions for the message field store: default geometry, fill-bank
// state encoding and the write-back field write record.
package fast_pkg;

  localparam int BEAT_W  = 64;
  localparam int MAX_MSG = 10;
  localparam int IDX_W   = $clog2(MAX_MSG);
  localparam int NL      = 4;
  localparam int MSGID_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] data;
  } field_write_t;

endpackage

// File: rtl/lane_merge.sv
// Per-index priority merge of the write lanes: the highest-numbered enabled lane
// targeting an index supplies its data; two or more hits on one index flag a collision.
module lane_merge #(
  parameter int NL   = 4,
  parameter int IW   = 4,
  parameter int MAXF = 10,
  parameter int W    = 64
) (
  input  logic [NL-1:0]     en_i,
  input  logic [NL*IW-1:0]  idx_i,
  input  logic [NL*W-1:0]   data_i,
  output logic [MAXF-1:0]   we_o,
  output logic [MAXF*W-1:0] wdata_o,
  output logic              collide_o
);

  always_comb begin
    we_o      = '0;
    wdata_o   = '0;
    collide_o = 1'b0;
    for (int j = 0; j < MAXF; j++) begin
      for (int l = 0; l < NL; l++) begin
        if (en_i[l] && (idx_i[l*IW +: IW] == IW'(j))) begin
          if (we_o[j]) collide_o = 1'b1;
          we_o[j]            = 1'b1;
          wdata_o[j*W +: W]  = data_i[l*W +: W];
        end
      end
    end
  end

endmodule

// File: rtl/message_field_store.sv
// Assembles per-lane field writes into a fill bank and hands completed messages
// to a double-buffered output register over a valid/ready interface.
module message_field_store
  import fast_pkg::*;
#(
  parameter int beat_width       = BEAT_W,
  parameter int max_message_size = MAX_MSG,
  parameter int sup_paths        = NL,
  parameter int messageID_size   = MSGID_W,
  parameter int IW               = $clog2(max_message_size),
  parameter int NLANE            = sup_paths
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   open_valid,
  output logic                                   open_ready,
  input  logic [messageID_size-1:0]              open_id,
  input  logic [IW:0]                            open_len,
  input  logic [0:NLANE-1]                       replace_field,
  input  logic [NLANE*IW-1:0]                    replace_field_idx,
  input  logic [NLANE*beat_width-1:0]            replacement_field,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [messageID_size-1:0]              out_id,
  output logic [IW:0]                            out_len,
  output logic [max_message_size*beat_width-1:0] out_fields,
  output logic                                   err_collide,
  output logic                                   err_oob
);

  localparam int W    = beat_width;
  localparam int MAXF = max_message_size;

  fill_state_e state_q, state_d;

  logic [messageID_size-1:0] id_q, id_d;
  logic [IW:0]               len_q, len_d;
  logic [MAXF-1:0]           bitmap_q, bitmap_d;
  logic [MAXF*W-1:0]         fields_q, fields_d;

  logic                      out_valid_q, out_valid_d;
  logic [messageID_size-1:0] out_id_q, out_id_d;
  logic [IW:0]               out_len_q, out_len_d;
  logic [MAXF*W-1:0]         out_fields_q, out_fields_d;

  logic err_collide_q, err_oob_q;

  logic              open_fire, xfer, complete, oob;
  logic [NLANE-1:0]  lane_en;
  logic [MAXF-1:0]   we;
  logic [MAXF*W-1:0] wdata;
  logic              collide;

  // Lane qualification: only in-range strobes during FILL reach the merge.
  always_comb begin
    lane_en = '0;
    oob     = 1'b0;
    for (int l = 0; l < NLANE; l++) begin
      if (replace_field[l]) begin
        if ((state_q == FILL) && ({1'b0, replace_field_idx[l*IW +: IW]} < len_q))
          lane_en[l] = 1'b1;
        else
          oob = 1'b1;
      end
    end
  end

  lane_merge #(
    .NL   (NLANE),
    .IW   (IW),
    .MAXF (MAXF),
    .W    (W)
  ) u_lane_merge (
    .en_i      (lane_en),
    .idx_i     (replace_field_idx),
    .data_i    (replacement_field),
    .we_o      (we),
    .wdata_o   (wdata),
    .collide_o (collide)
  );

  // Completion looks at the registered bitmap, so DONE lags the last write by one edge.
  always_comb begin
    complete = 1'b1;
    for (int j = 0; j < MAXF; j++) begin
      if (((IW+1)'(j) < len_q) && !bitmap_q[j]) complete = 1'b0;
    end
  end

  // Fill-bank FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fill-bank FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (open_fire) state_d = FILL;
      FILL:    if (complete)  state_d = DONE;
      DONE:    if (xfer)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill-bank FSM: outputs.
  always_comb begin
    open_ready = (state_q == IDLE);
    open_fire  = open_valid && open_ready;
    xfer       = (state_q == DONE) && (!out_valid_q || out_ready);
  end

  always_comb begin
    id_d     = id_q;
    len_d    = len_q;
    bitmap_d = bitmap_q;
    fields_d = fields_q;
    if (open_fire) begin
      id_d     = open_id;
      len_d    = open_len;
      bitmap_d = '0;
      fields_d = '0;
    end else if (xfer) begin
      id_d     = '0;
      len_d    = '0;
      bitmap_d = '0;
      fields_d = '0;
    end else begin
      for (int j = 0; j < MAXF; j++) begin
        if (we[j]) begin
          bitmap_d[j]        = 1'b1;
          fields_d[j*W +: W] = wdata[j*W +: W];
        end
      end
    end
  end

  // A transfer in the same cycle as a consumer accept keeps out_valid high with new contents.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_len_d    = out_len_q;
    out_fields_d = out_fields_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_id_d     = id_q;
      out_len_d    = len_q;
      out_fields_d = fields_q;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q          <= '0;
      len_q         <= '0;
      bitmap_q      <= '0;
      fields_q      <= '0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_len_q     <= '0;
      out_fields_q  <= '0;
      err_collide_q <= 1'b0;
      err_oob_q     <= 1'b0;
    end else begin
      id_q          <= id_d;
      len_q         <= len_d;
      bitmap_q      <= bitmap_d;
      fields_q      <= fields_d;
      out_valid_q   <= out_valid_d;
      out_id_q      <= out_id_d;
      out_len_q     <= out_len_d;
      out_fields_q  <= out_fields_d;
      err_collide_q <= collide;
      err_oob_q     <= oob;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign out_len     = out_len_q;
  assign out_fields  = out_fields_q;
  assign err_collide = err_collide_q;
  assign err_oob     = err_oob_q;

endmodule
